// File: rtl/ir_packet_tx.sv
// ir_packet_tx: serialises one IR car-control packet per SEND_PACKET strobe.
// A packet is: start, gap, car-select, gap, right, gap, left, gap, backward, gap,
// forward, gap. Bursts are carrier-modulated and gaps are silent.
// Ports:
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   SEND_PACKET  one-cycle start strobe; ignored while a packet is in flight
//   COMMAND      [3]=right [2]=left [1]=backward [0]=forward, latched on accept
//   IR_LED       registered, modulated IR output
//   BUSY         high while a packet is in flight
//   DONE         one-cycle pulse after the final gap completes
module ir_packet_tx #(
  parameter int unsigned CARRIER_HALF    = 1389,
  parameter int unsigned START_PULSES    = 191,
  parameter int unsigned GAP_PULSES      = 25,
  parameter int unsigned CARSEL_PULSES   = 47,
  parameter int unsigned ASSERT_PULSES   = 47,
  parameter int unsigned DEASSERT_PULSES = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_PACKET,
  input  logic [3:0] COMMAND,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] CARSEL = 3'd3;
  localparam logic [2:0] RIGHT  = 3'd4;
  localparam logic [2:0] LEFT   = 3'd5;
  localparam logic [2:0] BACK   = 3'd6;
  localparam logic [2:0] FWD    = 3'd7;

  // Phase spans a full carrier period, up to 2*65535-1.
  localparam int unsigned PhW = 17;
  localparam logic [PhW-1:0] PhaseLast = PhW'(2 * CARRIER_HALF - 1);
  localparam logic [PhW-1:0] PhaseHalf = PhW'(CARRIER_HALF);

  logic [2:0]     state_q, state_d;
  logic [2:0]     ret_q, ret_d;      // burst that follows the current gap
  logic [PhW-1:0] phase_q, phase_d;
  logic [9:0]     pulse_q, pulse_d;
  logic [3:0]     cmd_q, cmd_d;
  logic           led_q, led_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [9:0] seg_len;
  logic       in_burst;
  logic       wrap;
  logic       seg_end;

  always_comb begin
    seg_len = 10'd1;
    case (state_q)
      START:   seg_len = 10'(START_PULSES);
      GAP:     seg_len = 10'(GAP_PULSES);
      CARSEL:  seg_len = 10'(CARSEL_PULSES);
      RIGHT:   seg_len = cmd_q[3] ? 10'(ASSERT_PULSES) : 10'(DEASSERT_PULSES);
      LEFT:    seg_len = cmd_q[2] ? 10'(ASSERT_PULSES) : 10'(DEASSERT_PULSES);
      BACK:    seg_len = cmd_q[1] ? 10'(ASSERT_PULSES) : 10'(DEASSERT_PULSES);
      FWD:     seg_len = cmd_q[0] ? 10'(ASSERT_PULSES) : 10'(DEASSERT_PULSES);
      default: seg_len = 10'd1;
    endcase
  end

  assign in_burst = (state_q != IDLE) && (state_q != GAP);
  assign wrap     = (phase_q == PhaseLast);
  // A segment ends on the wrap that completes its last carrier period.
  assign seg_end  = wrap && (pulse_q == seg_len - 10'd1);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (SEND_PACKET) begin
        state_d = START;
        cmd_d   = COMMAND;
        phase_d = '0;
        pulse_d = '0;
      end
    end else if (seg_end) begin
      phase_d = '0;
      pulse_d = '0;
      if (state_q == GAP) begin
        state_d = ret_q;
        done_d  = (ret_q == IDLE);
      end else begin
        state_d = GAP;
        case (state_q)
          START:   ret_d = CARSEL;
          CARSEL:  ret_d = RIGHT;
          RIGHT:   ret_d = LEFT;
          LEFT:    ret_d = BACK;
          BACK:    ret_d = FWD;
          default: ret_d = IDLE;
        endcase
      end
    end else if (wrap) begin
      phase_d = '0;
      pulse_d = pulse_q + 10'd1;
    end else begin
      phase_d = phase_q + PhW'(1);
    end
    busy_d = (state_d != IDLE);
    led_d  = in_burst && (phase_q < PhaseHalf);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      cmd_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      cmd_q   <= cmd_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign IR_LED = led_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
